aes_inv_subbytes_seq: RTL and testbench

Sequential AES InvSubBytes engine. It is the decrypt-side counterpart to the forward S-box datapath. It accepts one 128-bit AES state over a valid/ready handshake and runs every byte through a shared inverse S-box, LANES bytes per cycle. It then presents the 128-bit result over a second valid/ready handshake. It sits between the round-key XOR and InvMixColumns stages of the AES-128 decrypt path.

---
 rtl/aes_inv_pkg.sv | 23 ++
 rtl/inv_sbox.sv | 28 ++
 rtl/aes_inv_subbytes_seq.sv | 104 ++++++++++
 tb/tb_aes_inv_subbytes_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_pkg.sv
// Shared state encoding, sizes and byte-permutation helper for the AES
// inverse SubBytes engine.
package aes_inv_pkg;

    localparam int NUM_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    // Source byte index feeding output byte i of InvShiftRows; byte i sits at
    // row (i mod 4), column (i div 4), and row r is rotated right by r columns.
    function automatic int inv_shift_rows_idx(input int i);
        int r;
        int c;
        r = i % 4;
        c = i / 4;
        return 4 * ((c - r + 4) % 4) + r;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational FIPS-197 inverse S-box, one byte in, one byte out.
module inv_sbox (
    input  logic [7:0] data,
    output logic [7:0] result
);

    localparam logic [0:255][7:0] INV_TABLE = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign result = INV_TABLE[data];

endmodule

// File: rtl/aes_inv_subbytes_seq.sv
// Sequential AES InvSubBytes engine: LANES bytes per cycle through shared inverse S-boxes.
// Define AES_INV_SHIFTROWS_EN to present the InvShiftRows of the result on out_data.
module aes_inv_subbytes_seq
    import aes_inv_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic [4:0] STEP = 5'(LANES);
    localparam logic [4:0] LAST = 5'(NUM_BYTES);

    state_e                      state_q;
    state_e                      state_d;
    logic [4:0]                  cnt_q;
    logic [0:NUM_BYTES-1][7:0]   work_q;
    logic [0:NUM_BYTES-1][7:0]   work_d;
    logic                        accept;
    logic                        last_group;

    logic [3:0] lane_idx [LANES];
    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];

    // Each lane looks at one byte of the current group; groups are LANES-aligned.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = cnt_q[3:0] + 4'(l);
        assign lane_in[l]  = work_q[lane_idx[l]];

        inv_sbox u_inv_sbox (
            .data   (lane_in[l]),
            .result (lane_out[l])
        );
    end

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        work_d = work_q;
        for (int l = 0; l < LANES; l++) begin
            work_d[lane_idx[l]] = lane_out[l];
        end
    end

    assign in_ready   = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept     = in_valid && in_ready;
    assign last_group = (cnt_q + STEP) == LAST;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (last_group) state_d = DONE;
            DONE:    if (out_ready) state_d = in_valid ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                work_q <= in_data;
                cnt_q  <= '0;
            end else if (state_q == BUSY) begin
                work_q <= work_d;
                cnt_q  <= cnt_q + STEP;
            end
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);

`ifdef AES_INV_SHIFTROWS_EN
    logic [0:NUM_BYTES-1][7:0] shifted;

    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_inv_shift_rows
        assign shifted[i] = work_q[inv_shift_rows_idx(i)];
    end

    assign out_data = shifted;
`else
    assign out_data = work_q;
`endif

endmodule

// File: tb/tb_aes_inv_subbytes_seq.sv
// Scoreboard bench for aes_inv_subbytes_seq: one instance with LANES=1 and one with LANES=16.
module tb_aes_inv_subbytes_seq;

    localparam int NDUT = 2;

    localparam logic [127:0] VA = {16{8'h63}};
    localparam logic [127:0] EA = 128'h0;
    localparam logic [127:0] VB = 128'h7c636363_63636316_63636363_636363ed;
    localparam logic [127:0] VC = 128'h637c6363_63636363_63636363_63636363;
    localparam logic [127:0] VD = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
`ifdef AES_INV_SHIFTROWS_EN
    localparam logic [127:0] EB = 128'h010000ff_00000000_00000053_00000000;
    localparam logic [127:0] EC = 128'h00000000_00010000_00000000_00000000;
    localparam logic [127:0] ED = 128'h000d0a07_04010e0b_0805020f_0c090603;
`else
    localparam logic [127:0] EB = 128'h01000000_000000ff_00000000_00000053;
    localparam logic [127:0] EC = 128'h00010000_00000000_00000000_00000000;
    localparam logic [127:0] ED = 128'h00010203_04050607_08090a0b_0c0d0e0f;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NDUT-1:0]   in_valid;
    logic [NDUT-1:0]   in_ready;
    logic [NDUT-1:0]   out_valid;
    logic [NDUT-1:0]   out_ready;
    logic [NDUT-1:0]   busy;
    logic [127:0]      in_data  [NDUT];
    logic [127:0]      out_data [NDUT];

    logic [127:0] exp_q0 [$];
    logic [127:0] exp_q1 [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        aes_inv_subbytes_seq #(.LANES(g == 0 ? 1 : 16)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int latency_of(input int d);
        return (d == 0) ? 16 : 1;
    endfunction

    task automatic push_exp(input int d, input logic [127:0] e);
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Monitor: every completed output handshake is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < NDUT; d++) begin
                if (out_valid[d] && out_ready[d]) begin
                    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL dut%0d unexpected output: got %h expected none", d, out_data[d]);
                    end else if (d == 0) begin
                        check("dut0 out_data", out_data[0], exp_q0.pop_front());
                    end else begin
                        check("dut1 out_data", out_data[1], exp_q1.pop_front());
                    end
                end
            end
        end
    end

    // Present one block and hold it until accepted; afterwards in_data is scrambled.
    task automatic send(input int d, input logic [127:0] data, input logic [127:0] e);
        int t;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        t = 0;
        @(negedge clk);
        while (!in_ready[d] && t < 100) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("dut%0d accept", d), 128'(in_ready[d]), 128'd1);
        push_exp(d, e);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_data[d]  = '1;
        check($sformatf("dut%0d busy after accept", d), 128'(busy[d]), 128'(latency_of(d) > 0));
    endtask

    // Count edges from the accept edge until out_valid is seen, then check latency.
    task automatic wait_valid(input int d);
        int cycles;
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!out_valid[d] && cycles < 100);
        check($sformatf("dut%0d latency", d), 128'(cycles), 128'(latency_of(d)));
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        for (int d = 0; d < NDUT; d++) in_data[d] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("dut%0d reset in_ready", d), 128'(in_ready[d]), 128'd1);
            check($sformatf("dut%0d reset out_valid", d), 128'(out_valid[d]), 128'd0);
            check($sformatf("dut%0d reset busy", d), 128'(busy[d]), 128'd0);
            check($sformatf("dut%0d reset out_data", d), out_data[d], 128'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int d = 0; d < NDUT; d++) begin
            // All 0x63 decodes to zero; latency measured with the output stalled.
            out_ready[d] = 1'b0;
            send(d, VA, EA);
            wait_valid(d);
            @(posedge clk);
            #1;
            out_ready[d] = 1'b1;
            @(posedge clk);
            #1;

            // Per-byte vector under 20 cycles of backpressure.
            out_ready[d] = 1'b0;
            send(d, VB, EB);
            wait_valid(d);
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                check($sformatf("dut%0d hold out_valid", d), 128'(out_valid[d]), 128'd1);
                check($sformatf("dut%0d hold in_ready", d), 128'(in_ready[d]), 128'd0);
                check($sformatf("dut%0d hold out_data", d), out_data[d], EB);
            end

            // Back-to-back: new block offered in the same cycle the result drains.
            @(posedge clk);
            #1;
            in_valid[d]  = 1'b1;
            in_data[d]   = VC;
            out_ready[d] = 1'b1;
            push_exp(d, EC);
            @(negedge clk);
            check($sformatf("dut%0d b2b in_ready", d), 128'(in_ready[d]), 128'd1);
            @(posedge clk);
            #1;
            in_valid[d] = 1'b0;
            in_data[d]  = '1;
            check($sformatf("dut%0d b2b busy", d), 128'(busy[d]), 128'd1);
            wait_valid(d);
            @(posedge clk);
            #1;

            // Free-flowing block with distinct byte values.
            send(d, VD, ED);
            wait_valid(d);
            @(posedge clk);
            #1;
            out_ready[d] = 1'b0;
        end

        // Reset during BUSY cycle 5 discards the block.
        send(0, VB, EB);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q0.delete();
        #1;
        check("reset mid out_valid", 128'(out_valid[0]), 128'd0);
        check("reset mid out_data", out_data[0], 128'd0);
        check("reset mid in_ready", 128'(in_ready[0]), 128'd1);
        check("reset mid busy", 128'(busy[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        send(0, VC, EC);
        wait_valid(0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("dut0 scoreboard drained", 128'(exp_q0.size()), 128'd0);
        check("dut1 scoreboard drained", 128'(exp_q1.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
